pipe_stage_skid: RTL and testbench

- Parametrised successor to the fixed IF/ID pipeline register: a generic inter-stage register for any pipeline boundary (IF/ID, ID/EX, EX/MEM).
- Uses a valid/ready handshake instead of a bare write-disable, with a 2-entry skid buffer. Back-pressure is therefore fully registered: no combinational path from out_ready to in_ready.
- Keeps synchronous flush with bubble insertion and adds a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_stage_skid.sv | 131 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Back-pressure is fully registered; flush inserts a bubble; stall cycles are counted (saturating).
module pipe_stage_skid #(
    parameter int unsigned           WIDTH     = 64,
    parameter logic [WIDTH-1:0]      NOP_VALUE = {WIDTH{1'b0}},
    parameter int unsigned           CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             in_flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] stall_cnt
);

    // Bit 0 is valid_m, bit 1 is valid_s; 2'b10 (skid without main) is illegal.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_m_q, data_m_d;
    logic [WIDTH-1:0]   data_s_q, data_s_d;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic               valid_m;
    logic               in_fire;
    logic               out_fire;

    assign valid_m  = state_q[0];
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = valid_m & out_ready;

    // State register. The data entries are reset too so out_data and storage
    // start at NOP_VALUE.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            data_m_q    <= NOP_VALUE;
            data_s_q    <= NOP_VALUE;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            data_m_q    <= data_m_d;
            data_s_q    <= data_s_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state and storage update; flush overrides every handshake outcome.
    // NOTE: every signal written here gets a hold default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        data_m_d = data_m_q;
        data_s_d = data_s_q;

        if (in_flush) begin
            state_d  = EMPTY;
            data_m_d = NOP_VALUE;
            data_s_d = NOP_VALUE;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d  = ONE;
                        data_m_d = in_data;
                    end
                end
                ONE: begin
                    case ({in_fire, out_fire})
                        2'b11: data_m_d = in_data;
                        2'b10: begin
                            state_d  = TWO;
                            data_s_d = in_data;
                        end
                        2'b01: begin
                            state_d  = EMPTY;
                            data_m_d = NOP_VALUE;
                        end
                        default: ;
                    endcase
                end
                TWO: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_fire) begin
                        state_d  = ONE;
                        data_m_d = data_s_q;
                        data_s_d = NOP_VALUE;
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    data_m_d = NOP_VALUE;
                    data_s_d = NOP_VALUE;
                end
            endcase
        end

        // Ready is registered from the next state: no out_ready -> in_ready path.
        in_ready_d = (state_d != TWO);
    end

    // Saturating stall counter; flush cycles count as well.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_m && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Outputs come straight from flops (plus the NOP mux on the data path).
    always_comb begin
        out_valid = valid_m;
        out_data  = valid_m ? data_m_q : NOP_VALUE;
        in_ready  = in_ready_q;
        stall_cnt = stall_cnt_q;
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: vector table plus scoreboard, with
// hand-written reset, async-reset and counter-saturation sequences.
module tb_pipe_stage_skid;

    localparam int unsigned W  = 64;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          in_flush;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [CW-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] sb[$];

    typedef struct {
        logic         in_valid;
        logic [W-1:0] in_data;
        logic         in_flush;
        logic         out_ready;
        logic         exp_valid;
        logic [W-1:0] exp_data;
        logic         exp_ready;
    } vec_t;

    vec_t vecs[$];

    pipe_stage_skid #(
        .WIDTH     (W),
        .NOP_VALUE ({W{1'b0}}),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .in_flush  (in_flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic v, input logic [W-1:0] d, input logic f, input logic r,
                           input logic ev, input logic [W-1:0] ed, input logic er);
        vec_t t;
        t.in_valid = v;  t.in_data = d;  t.in_flush = f; t.out_ready = r;
        t.exp_valid = ev; t.exp_data = ed; t.exp_ready = er;
        vecs.push_back(t);
    endtask

    // One clock cycle: drive at the falling edge, update the scoreboard from
    // the pre-edge handshake, return 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic f, input logic r);
        logic [W-1:0] exp_word;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_flush  = f;
        out_ready = r;
        #1;
        if (reset) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got unexpected word %h expected none", out_data);
                end else begin
                    exp_word = sb.pop_front();
                    check("sb_data", out_data, exp_word);
                end
            end
            if (in_flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hDEAD;
        in_flush  = 1'b0;
        out_ready = 1'b0;

        // Reset held with a valid payload presented.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data",  out_data, 64'd0);
        check("rst_in_ready",  {63'd0, in_ready}, 64'd1);
        check("rst_stall_cnt", {60'd0, stall_cnt}, 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;

        // Streaming 1..8 at full rate: each word visible one cycle after in_fire.
        for (int i = 1; i <= 8; i++) add_vec(1'b1, 64'(i), 1'b0, 1'b1, 1'b1, 64'(i), 1'b1);
        add_vec(1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 64'h0,  1'b1);
        // Back-pressure: A in M, B in S, C held upstream, then drain in order.
        add_vec(1'b1, 64'h11, 1'b0, 1'b0, 1'b1, 64'h11, 1'b1);
        add_vec(1'b1, 64'h22, 1'b0, 1'b0, 1'b1, 64'h11, 1'b0);
        add_vec(1'b1, 64'h33, 1'b0, 1'b0, 1'b1, 64'h11, 1'b0);
        add_vec(1'b1, 64'h33, 1'b0, 1'b1, 1'b1, 64'h22, 1'b1);
        add_vec(1'b1, 64'h33, 1'b0, 1'b1, 1'b1, 64'h33, 1'b1);
        add_vec(1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 64'h0,  1'b1);
        // Flush from TWO with D presented: everything discarded.
        add_vec(1'b1, 64'h11, 1'b0, 1'b0, 1'b1, 64'h11, 1'b1);
        add_vec(1'b1, 64'h22, 1'b0, 1'b0, 1'b1, 64'h11, 1'b0);
        add_vec(1'b1, 64'h44, 1'b1, 1'b0, 1'b0, 64'h0,  1'b1);
        add_vec(1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 64'h0,  1'b1);
        // Flush with a concurrent out_fire: E still delivered, F discarded.
        add_vec(1'b1, 64'h55, 1'b0, 1'b1, 1'b1, 64'h55, 1'b1);
        add_vec(1'b1, 64'h66, 1'b1, 1'b1, 1'b0, 64'h0,  1'b1);
        add_vec(1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 64'h0,  1'b1);
        // Hold in ONE, then drain.
        add_vec(1'b1, 64'h77, 1'b0, 1'b0, 1'b1, 64'h77, 1'b1);
        add_vec(1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h77, 1'b1);
        add_vec(1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 64'h0,  1'b1);

        foreach (vecs[i]) begin
            step(vecs[i].in_valid, vecs[i].in_data, vecs[i].in_flush, vecs[i].out_ready);
            check($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].exp_valid});
            check($sformatf("v%0d_out_data", i),  out_data, vecs[i].exp_data);
            check($sformatf("v%0d_in_ready", i),  {63'd0, in_ready}, {63'd0, vecs[i].exp_ready});
        end
        // Stall cycles in the table: two in back-pressure, two in flush test
        // (including the flush cycle itself), one in the hold test.
        check("table_stall_cnt", {60'd0, stall_cnt}, 64'd5);
        check("table_sb_empty", 64'(sb.size()), 64'd0);

        // Async reset pulse between clock edges while in TWO.
        step(1'b1, 64'hA1, 1'b0, 1'b0);
        step(1'b1, 64'hB2, 1'b0, 1'b0);
        check("two_in_ready", {63'd0, in_ready}, 64'd0);
        #1 reset = 1'b0;
        #1;
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_out_data",  out_data, 64'd0);
        check("arst_in_ready",  {63'd0, in_ready}, 64'd1);
        check("arst_stall_cnt", {60'd0, stall_cnt}, 64'd0);
        sb.delete();
        #1 reset = 1'b1;
        step(1'b0, 64'h0, 1'b0, 1'b1);
        check("post_arst_out_valid", {63'd0, out_valid}, 64'd0);

        // Counter saturation at 2^CW-1 = 15.
        step(1'b1, 64'hC3, 1'b0, 1'b0);
        check("sat_start", {60'd0, stall_cnt}, 64'd0);
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 64'h0, 1'b0, 1'b0);
            if (k == 14 || k == 15 || k == 20)
                check($sformatf("sat_k%0d", k), {60'd0, stall_cnt}, (k > 15) ? 64'd15 : 64'(k));
        end
        check("sat_data_held", out_data, 64'hC3);
        step(1'b0, 64'h0, 1'b0, 1'b1);
        step(1'b0, 64'h0, 1'b0, 1'b1);
        check("sat_stall_hold", {60'd0, stall_cnt}, 64'd15);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
